// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Purpose: releases NUM_CH reset channels one after another once the global
// reset rst has been removed. rst deassertion is first synchronised to clk
// through a SYNC_STAGES-deep flop chain. All channels are then held for
// HOLD_MIN cycles, after which channel 0 is released, then channel 1 STAGGER
// cycles later, and so on in ascending order. seq_done rises one cycle after
// the last channel is released. Assertion of rst is asynchronous: every
// channel re-asserts immediately, without waiting for a clock edge.
//
// Optional feature, macro RST_SEQ_SW_RESET_EN: adds sw_rst_req, a
// level-sensitive software reset. It re-asserts all channels and restarts
// the sequence from HOLD (the synchroniser stage is not revisited). It is
// ignored while the block is still in SYNC.
//
// Parameters:
//   NUM_CH      number of reset channels (1..32)
//   SYNC_STAGES depth of the deassertion synchroniser (2..4)
//   HOLD_MIN    cycles all channels stay asserted after synchronisation (1..1023)
//   STAGGER     cycles between release of consecutive channels (1..255)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   sw_rst_req   software reset request (only with RST_SEQ_SW_RESET_EN)
//   reset_out    per-channel reset, active-high, registered
//   reset_out_n  per-channel reset, active-low, registered (~reset_out)
//   seq_done     high once every channel has been released, registered
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_MIN    = 16,
    parameter int STAGGER     = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RST_SEQ_SW_RESET_EN
    input  logic              sw_rst_req,
`endif
    output logic [NUM_CH-1:0] reset_out,
    output logic [NUM_CH-1:0] reset_out_n,
    output logic              seq_done
);

    // One counter serves both the hold and the stagger phases; it only ever
    // counts up to (max count - 1), so $clog2 of the max count never wraps.
    localparam int CNT_MAX = (HOLD_MIN > STAGGER) ? HOLD_MIN : STAGGER;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MIN - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic [CNT_W-1:0]       cnt;

    // Deassertion synchroniser: set asynchronously by rst, shifts zeros in
    // from bit 0 on each edge once rst is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // Sequencing FSM. reset_out holds a contiguous block of ones at the top;
    // each release shifts one zero in from bit 0, which enforces the
    // ascending release order and makes "all released" simply reset_out==0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SYNC;
            cnt         <= '0;
            reset_out   <= '1;
            reset_out_n <= '0;
            seq_done    <= 1'b0;
        end else begin
`ifdef RST_SEQ_SW_RESET_EN
            // A held request keeps reloading HOLD with cnt=0, so the hold
            // count effectively starts on the first edge with the request low.
            if (sw_rst_req && (state != SYNC)) begin
                state       <= HOLD;
                cnt         <= '0;
                reset_out   <= '1;
                reset_out_n <= '0;
                seq_done    <= 1'b0;
            end else
`endif
            begin
                case (state)
                    SYNC: begin
                        // Leave on the edge where the synchroniser output
                        // falls: output still high, its predecessor already low.
                        if (sync_ff[SYNC_STAGES-1] && !sync_ff[SYNC_STAGES-2]) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt         <= '0;
                            reset_out   <= reset_out << 1;
                            reset_out_n <= ~(reset_out << 1);
                            state       <= RELEASE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RELEASE: begin
                        // Checked first so a single channel goes straight
                        // to DONE with no stagger wait.
                        if (reset_out == '0) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end else if (cnt == STAG_LAST) begin
                            cnt         <= '0;
                            reset_out   <= reset_out << 1;
                            reset_out_n <= ~(reset_out << 1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= SYNC;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//
// Two instances share clk/rst: a default-parameter instance (4 channels) and
// a corner instance (NUM_CH=1, SYNC_STAGES=3, HOLD_MIN=1). Stimulus pushes
// the expected output changes {reset_out, seq_done, edge number} into one
// queue per instance; a monitor per instance pops an entry each time the
// outputs change and compares value and edge. Edge numbers are absolute
// clock counts (cyc); edge n of a sequence is base+n, base being cyc at the
// moment rst is released.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [3:0] ro;
    logic [3:0] ro_n;
    logic       done;
    logic [0:0] c_ro;
    logic [0:0] c_ro_n;
    logic       c_done;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int base   = 0;

    typedef struct {
        int         edge_n;   // -1: any edge (used for rst assertion)
        logic [3:0] ro;
        logic       done;
    } exp_t;

    exp_t q_m[$];
    exp_t q_c[$];

    logic [4:0] prev_m = 5'bx;
    logic [4:0] prev_c = 5'bx;

    reset_sequencer #(
        .NUM_CH(4), .SYNC_STAGES(2), .HOLD_MIN(16), .STAGGER(8)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
`ifdef RST_SEQ_SW_RESET_EN
        .sw_rst_req (sw_rst_req),
`endif
        .reset_out  (ro),
        .reset_out_n(ro_n),
        .seq_done   (done)
    );

    reset_sequencer #(
        .NUM_CH(1), .SYNC_STAGES(3), .HOLD_MIN(1), .STAGGER(8)
    ) u_corner (
        .clk        (clk),
        .rst        (rst),
`ifdef RST_SEQ_SW_RESET_EN
        .sw_rst_req (sw_rst_req),
`endif
        .reset_out  (c_ro),
        .reset_out_n(c_ro_n),
        .seq_done   (c_done)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_m(input int e, input logic [3:0] r, input logic d);
        exp_t x;
        x.edge_n = e; x.ro = r; x.done = d;
        q_m.push_back(x);
    endtask

    task automatic push_c(input int e, input logic r, input logic d);
        exp_t x;
        x.edge_n = e; x.ro = {3'b000, r}; x.done = d;
        q_c.push_back(x);
    endtask

    // Return 1 ns after the rising edge that makes cyc == n.
    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: main instance
    always @(negedge clk) begin
        exp_t       x;
        logic [4:0] cur;
        n_chk++;
        if (ro_n !== ~ro) begin
            n_fail++;
            $display("FAIL main_complement cyc=%0d reset_out_n=%b required=%b", cyc, ro_n, ~ro);
        end
        cur = {ro, done};
        if (cur !== prev_m) begin
            prev_m = cur;
            n_chk++;
            if (q_m.size() == 0) begin
                n_fail++;
                $display("FAIL main_unexpected_change cyc=%0d reset_out=%b seq_done=%b required=no change",
                         cyc, ro, done);
            end else begin
                x = q_m.pop_front();
                if (cur !== {x.ro, x.done} || (x.edge_n >= 0 && x.edge_n != cyc)) begin
                    n_fail++;
                    $display("FAIL main_seq cyc=%0d reset_out=%b seq_done=%b required cyc=%0d reset_out=%b seq_done=%b",
                             cyc, ro, done, x.edge_n, x.ro, x.done);
                end
            end
        end
    end

    // Monitor: corner instance
    always @(negedge clk) begin
        exp_t       x;
        logic [4:0] cur;
        n_chk++;
        if (c_ro_n !== ~c_ro) begin
            n_fail++;
            $display("FAIL corner_complement cyc=%0d reset_out_n=%b required=%b", cyc, c_ro_n, ~c_ro);
        end
        cur = {3'b000, c_ro, c_done};
        if (cur !== prev_c) begin
            prev_c = cur;
            n_chk++;
            if (q_c.size() == 0) begin
                n_fail++;
                $display("FAIL corner_unexpected_change cyc=%0d reset_out=%b seq_done=%b required=no change",
                         cyc, c_ro, c_done);
            end else begin
                x = q_c.pop_front();
                if (cur !== {x.ro, x.done} || (x.edge_n >= 0 && x.edge_n != cyc)) begin
                    n_fail++;
                    $display("FAIL corner_seq cyc=%0d reset_out=%b seq_done=%b required cyc=%0d reset_out=%b seq_done=%b",
                             cyc, c_ro, c_done, x.edge_n, x.ro[0], x.done);
                end
            end
        end
    end

    initial begin
        // ---------------- power-on sequence ----------------
        push_m(-1, 4'b1111, 1'b0);
        push_c(-1, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
`ifdef RST_SEQ_SW_RESET_EN
        // Request present at edge 1 while still in SYNC: must be ignored.
        sw_rst_req = 1'b1;
`endif
        push_m(base + 18, 4'b1110, 1'b0);
        push_m(base + 26, 4'b1100, 1'b0);
        push_m(base + 34, 4'b1000, 1'b0);
        push_m(base + 42, 4'b0000, 1'b0);
        push_m(base + 43, 4'b0000, 1'b1);
        push_c(base + 4, 1'b0, 1'b0);
        push_c(base + 5, 1'b0, 1'b1);
        wait_edge(base + 1);
        sw_rst_req = 1'b0;

`ifdef RST_SEQ_SW_RESET_EN
        // ---------------- software reset, edges 50..54 ----------------
        wait_edge(base + 49);
        push_m(base + 50, 4'b1111, 1'b0);
        push_m(base + 70, 4'b1110, 1'b0);
        push_m(base + 78, 4'b1100, 1'b0);
        push_m(base + 86, 4'b1000, 1'b0);
        push_m(base + 94, 4'b0000, 1'b0);
        push_m(base + 95, 4'b0000, 1'b1);
        push_c(base + 50, 1'b1, 1'b0);
        push_c(base + 55, 1'b0, 1'b0);
        push_c(base + 56, 1'b0, 1'b1);
        sw_rst_req = 1'b1;
        wait_edge(base + 54);
        sw_rst_req = 1'b0;
        wait_edge(base + 100);
`else
        wait_edge(base + 60);
`endif

        // ---------------- mid-sequence short rst pulse ----------------
        push_m(-1, 4'b1111, 1'b0);
        push_c(-1, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        push_m(base + 18, 4'b1110, 1'b0);
        push_m(base + 26, 4'b1100, 1'b0);
        push_m(base + 30, 4'b1111, 1'b0);
        push_m(base + 48, 4'b1110, 1'b0);
        push_m(base + 56, 4'b1100, 1'b0);
        push_m(base + 64, 4'b1000, 1'b0);
        push_m(base + 72, 4'b0000, 1'b0);
        push_m(base + 73, 4'b0000, 1'b1);
        push_c(base + 4, 1'b0, 1'b0);
        push_c(base + 5, 1'b0, 1'b1);
        push_c(base + 30, 1'b1, 1'b0);
        push_c(base + 34, 1'b0, 1'b0);
        push_c(base + 35, 1'b0, 1'b1);
        wait_edge(base + 30);
        rst = 1'b1;
        #1;
        // Mid-cycle, no clock edge since rst rose: outputs must already be reset.
        n_chk++;
        if (ro !== 4'b1111 || ro_n !== 4'b0000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL main_async_reset reset_out=%b reset_out_n=%b seq_done=%b required 1111 0000 0",
                     ro, ro_n, done);
        end
        n_chk++;
        if (c_ro !== 1'b1 || c_ro_n !== 1'b0 || c_done !== 1'b0) begin
            n_fail++;
            $display("FAIL corner_async_reset reset_out=%b reset_out_n=%b seq_done=%b required 1 0 0",
                     c_ro, c_ro_n, c_done);
        end
        #1;
        rst = 1'b0;
        wait_edge(base + 80);

        // Every expected change must have been observed.
        n_chk++;
        if (q_m.size() != 0) begin
            n_fail++;
            $display("FAIL main_pending actual=%0d unmatched entries required=0 (next cyc=%0d)",
                     q_m.size(), q_m[0].edge_n);
        end
        n_chk++;
        if (q_c.size() != 0) begin
            n_fail++;
            $display("FAIL corner_pending actual=%0d unmatched entries required=0 (next cyc=%0d)",
                     q_c.size(), q_c[0].edge_n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
